// File: rtl/cpu_defs_pkg.sv
// Shared instruction encoding, field positions and decoded bundle type.
// No logic; types and constants only.
// Used by the decoder top and its output skid buffer.
package cpu_defs_pkg;

    typedef logic [31:0] instr_t;
    typedef logic [31:0] addr_t;

    // Opcode lives in instr[31:28]; 5..E are unassigned and decode as illegal.
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_ADDI  = 4'h2,
        OP_LOAD  = 4'h3,
        OP_STORE = 4'h4,
        OP_HALT  = 4'hF
    } opcode_t;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Field order here is the bit order of the packed bundle (op is the MSBs).
    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        addr_t       pc;
    } decoded_t;

    // Opcodes with no assigned meaning.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'h5) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/cpu_decode_skid.sv
// Two-entry FIFO of decoded bundles between decode and execute; head drives the outputs.
// Latency: a push is visible at the head the next cycle when empty or draining.
// Backpressure: o_in_rdy drops only when both entries are occupied; independent of i_out_rdy.
module cpu_decode_skid
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_flush,
    input  logic     i_in_vld,
    output logic     o_in_rdy,
    input  decoded_t i_in_dat,
    output logic     o_out_vld,
    input  logic     i_out_rdy,
    output decoded_t o_out_dat
);

    localparam logic [1:0] LP_FULL = 2'(DEPTH);

    decoded_t   r_ent0;
    decoded_t   r_ent1;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_in_rdy  = (r_count < LP_FULL);
    assign o_out_vld = (r_count != 2'd0);
    // Empty buffer presents an all-zero bundle so stale entries never leak out.
    assign o_out_dat = o_out_vld ? r_ent0 : '0;

    assign w_push = i_in_vld & o_in_rdy;
    assign w_pop  = i_out_rdy & o_out_vld;

    // Entry shifting and occupancy; entry 0 is always the oldest.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= i_in_dat;
                    end else begin
                        r_ent1 <= i_in_dat;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_in_dat;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_in_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_instr_decoder.sv
// Decodes fetch words into control/operand bundles, tracks busy registers, stalls RAW/WAW hazards.
// Latency: one cycle from accept to out_* when the skid buffer is empty or draining.
// Backpressure: in_ready low when halted, flushing, buffer full, or a source/dest register is busy.
module cpu_instr_decoder
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_we,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_illegal,
    output logic [31:0] out_pc,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    output logic        halted
);

    logic [NUM_REGS-1:0] r_busy;
    logic                r_halted;

    logic [3:0]          w_raw_op;
    decoded_t            w_dec;
    decoded_t            w_head;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_stops;
    logic                w_hazard;
    logic                w_skid_rdy;
    logic                w_accept;
    logic [NUM_REGS-1:0] w_busy_nxt;

    assign w_raw_op = in_instr[OP_MSB:OP_LSB];

    // Combinational decode of the presented fetch word into a bundle plus operand-use flags.
    always_comb begin
        w_dec         = '0;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_stops       = 1'b0;
        w_dec.rd      = in_instr[RD_MSB:RD_LSB];
        w_dec.rs1     = in_instr[RS1_MSB:RS1_LSB];
        w_dec.rs2     = in_instr[RS2_MSB:RS2_LSB];
        w_dec.imm     = {{16{in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};
        w_dec.pc      = in_pc;
        w_dec.op      = OP_NOP;
        case (w_raw_op)
            OP_NOP: begin
            end
            OP_ADD: begin
                w_dec.op  = OP_ADD;
                w_dec.we  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_ADDI: begin
                w_dec.op  = OP_ADDI;
                w_dec.we  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                w_dec.op     = OP_LOAD;
                w_dec.we     = 1'b1;
                w_dec.mem_rd = 1'b1;
                w_use_rs1    = 1'b1;
            end
            OP_STORE: begin
                w_dec.op     = OP_STORE;
                w_dec.mem_wr = 1'b1;
                w_use_rs1    = 1'b1;
                w_use_rs2    = 1'b1;
            end
            OP_HALT: begin
                w_dec.op = OP_HALT;
                w_stops  = 1'b1;
            end
            default: begin
                // Unassigned opcodes travel as a NOP tagged illegal and stop further fetch.
                w_dec.illegal = is_illegal_op(w_raw_op);
                w_stops       = 1'b1;
            end
        endcase
    end

    // Writeback in the same cycle does not bypass: the registered busy bits alone decide the stall.
    assign w_hazard = (w_use_rs1 & r_busy[w_dec.rs1])
                    | (w_use_rs2 & r_busy[w_dec.rs2])
                    | (w_dec.we  & r_busy[w_dec.rd]);

    assign in_ready = ~r_halted & ~flush & w_skid_rdy & ~w_hazard;
    assign w_accept = in_valid & in_ready;
    assign halted   = r_halted;

    // Next busy vector: retire first, then a new writer claims its register so set wins on a tie.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_accept && w_dec.we) begin
            w_busy_nxt[w_dec.rd] = 1'b1;
        end
    end

    // Register busy scoreboard; flush discards all outstanding writers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Sticky halt after accepting HALT or an illegal word; only reset or flush releases it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_halted <= 1'b0;
        end else if (w_accept && w_stops) begin
            r_halted <= 1'b1;
        end
    end

    cpu_decode_skid #(
        .DEPTH (DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_in_vld  (w_accept),
        .o_in_rdy  (w_skid_rdy),
        .i_in_dat  (w_dec),
        .o_out_vld (out_valid),
        .i_out_rdy (out_ready),
        .o_out_dat (w_head)
    );

    assign out_op      = w_head.op;
    assign out_rd      = w_head.rd;
    assign out_rs1     = w_head.rs1;
    assign out_rs2     = w_head.rs2;
    assign out_imm     = w_head.imm;
    assign out_we      = w_head.we;
    assign out_mem_rd  = w_head.mem_rd;
    assign out_mem_wr  = w_head.mem_wr;
    assign out_illegal = w_head.illegal;
    assign out_pc      = w_head.pc;

endmodule

// File: tb/tb_cpu_instr_decoder.sv
// Scoreboard bench for cpu_instr_decoder: directed scenarios followed by randomized traffic.
// Latency: expected bundles are queued on accept and checked at the head every cycle.
// Backpressure: out_ready, writeback and flush are randomized to exercise stalls and drains.
module tb_cpu_instr_decoder;
    import cpu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic        wb_valid, halted, out_we, out_mem_rd, out_mem_wr, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [3:0]  out_op, out_rd, out_rs1, out_rs2, wb_rd;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending bundles in order, busy registers, halt flag.
    decoded_t  m_q[$];
    bit [15:0] m_busy;
    bit        m_halted;

    decoded_t    c_e;
    int          c_op;
    bit          c_haz, c_rdy;
    logic [87:0] c_act;

    cpu_instr_decoder dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_we(out_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_illegal(out_illegal), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int op_of(input logic [31:0] w);
        return int'(w >> 28);
    endfunction

    function automatic bit writes_rd(input int op);
        return (op == 1) || (op == 2) || (op == 3);
    endfunction

    function automatic bit reads_rs1(input int op);
        return (op >= 1) && (op <= 4);
    endfunction

    function automatic bit reads_rs2(input int op);
        return (op == 1) || (op == 4);
    endfunction

    // What execute should see for a given word, from the ISA rules.
    function automatic decoded_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        decoded_t e;
        int op, s;
        op    = op_of(w);
        e     = '0;
        e.rd  = 4'((w >> 24) & 32'hF);
        e.rs1 = 4'((w >> 20) & 32'hF);
        e.rs2 = 4'((w >> 16) & 32'hF);
        s     = int'(w & 32'hFFFF);
        if (s >= 32768) s = s - 65536;
        e.imm = 32'(s);
        e.pc  = pc;
        if (op >= 5 && op <= 14) begin
            e.op      = 4'h0;
            e.illegal = 1'b1;
        end else begin
            e.op     = 4'(op);
            e.we     = writes_rd(op);
            e.mem_rd = (op == 3);
            e.mem_wr = (op == 4);
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
        return 32'((op << 28) | (rd << 24) | (rs1 << 20) | (rs2 << 16) | (imm & 32'hFFFF));
    endfunction

    function automatic logic [31:0] rand_instr();
        int r, op;
        r = $urandom_range(0, 19);
        if (r < 16)      op = r % 5;
        else if (r < 18) op = 15;
        else             op = $urandom_range(5, 14);
        return mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), int'($urandom));
    endfunction

    // Monitor: just before each rising edge, compare DUT against the model, then advance the model.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            m_q.delete();
            m_busy   = '0;
            m_halted = 1'b0;
        end else begin
            c_e   = ref_decode(in_instr, in_pc);
            c_op  = op_of(in_instr);
            c_haz = (reads_rs1(c_op) && m_busy[c_e.rs1]) || (reads_rs2(c_op) && m_busy[c_e.rs2])
                  || (writes_rd(c_op) && m_busy[c_e.rd]);
            c_rdy = !m_halted && !flush && (m_q.size() < 2) && !c_haz;
            chk("in_ready", in_ready, c_rdy);
            chk("halted", halted, m_halted);
            chk("out_valid", out_valid, m_q.size() != 0);
            c_act = {out_op, out_rd, out_rs1, out_rs2, out_imm, out_we, out_mem_rd, out_mem_wr, out_illegal, out_pc};
            if (out_valid && m_q.size() > 0) chk("out_bundle", c_act, m_q[0]);
            if (out_valid && out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (flush) begin
                m_q.delete();
                m_busy   = '0;
                m_halted = 1'b0;
            end else begin
                if (wb_valid) m_busy[wb_rd] = 1'b0;
                if (in_valid && in_ready) begin
                    m_q.push_back(c_e);
                    if (c_e.we) m_busy[c_e.rd] = 1'b1;
                    if (c_op == 15 || c_e.illegal) m_halted = 1'b1;
                end
            end
        end
    end

    // Present a word until accepted or the cycle budget expires; caller sits just after a falling edge.
    task automatic send(input logic [31:0] w, input logic [31:0] pc, input int budget, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        for (int i = 0; i < budget && !ok; i++) begin
            #4;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic retire(input logic [3:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    bit ok0, ok1, ok2, acc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", {out_op, out_rd, out_rs1, out_rs2, out_imm, out_we, out_mem_rd,
                           out_mem_wr, out_illegal, out_pc}, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);

        // ADDI r1,r0,0xFFFF: sign-extended immediate next cycle.
        send(mk(2, 1, 0, 0, 16'hFFFF), 32'h10, 5, ok0);
        chk("t1_accept", ok0, 1);
        #4;
        chk("t1_imm", out_imm, 32'hFFFF_FFFF);
        chk("t1_we", out_we, 1);
        chk("t1_rd", out_rd, 1);
        chk("t1_pc", out_pc, 32'h10);
        @(negedge clk);
        retire(4'd1);

        // ADD r2,r1,r1 stalls behind ADDI r1 until r1 retires, including the retire cycle.
        send(mk(2, 1, 0, 0, 5), 32'h14, 5, ok0);
        in_valid = 1'b1; in_instr = mk(1, 2, 1, 1, 0); in_pc = 32'h18;
        repeat (3) begin
            #4; chk("t2_stall", in_ready, 0);
            @(negedge clk);
        end
        wb_valid = 1'b1; wb_rd = 4'd1;
        #4; chk("t2_wb_cycle_stall", in_ready, 0);
        @(negedge clk);
        wb_valid = 1'b0;
        #4; chk("t2_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        retire(4'd2);

        // Three NOPs against a blocked consumer: two buffered, third waits, all drain in order.
        out_ready = 1'b0;
        fork
            begin
                send(mk(0, 0, 0, 0, 0), 32'h20, 10, ok0);
                send(mk(0, 0, 0, 0, 0), 32'h24, 10, ok1);
                send(mk(0, 0, 0, 0, 0), 32'h28, 10, ok2);
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        chk("t3_accept_all", {ok0, ok1, ok2}, 3'b111);
        repeat (3) @(negedge clk);

        // Illegal word: NOP tagged illegal, halts, next word refused.
        send(32'h7000_0000, 32'h40, 3, ok0);
        chk("t4_accept", ok0, 1);
        #4;
        chk("t4_op", out_op, 0);
        chk("t4_illegal", out_illegal, 1);
        chk("t4_halted", halted, 1);
        @(negedge clk);
        send(mk(0, 0, 0, 0, 0), 32'h44, 4, ok0);
        chk("t4_refused", ok0, 0);
        do_flush();

        // HALT then ADDI refused; flush releases.
        send(mk(15, 0, 0, 0, 0), 32'h50, 3, ok0);
        chk("t5_halt_accept", ok0, 1);
        send(mk(2, 4, 0, 0, 1), 32'h54, 4, ok0);
        chk("t5_refused", ok0, 0);
        do_flush();
        #4; chk("t5_unhalted", halted, 0);
        @(negedge clk);
        send(mk(2, 4, 0, 0, 1), 32'h54, 3, ok0);
        chk("t5_accept_after_flush", ok0, 1);

        // LOAD r3 with a same-cycle retire of r3: busy stays set, STORE r3 stalls until next retire.
        in_valid = 1'b1; in_instr = mk(3, 3, 0, 0, 8); in_pc = 32'h60;
        wb_valid = 1'b1; wb_rd = 4'd3;
        #4; chk("t6_load_accept", in_ready, 1);
        @(negedge clk);
        wb_valid = 1'b0;
        in_instr = mk(4, 0, 3, 1, 0); in_pc = 32'h64;
        repeat (3) begin
            #4; chk("t6_store_stall", in_ready, 0);
            @(negedge clk);
        end
        wb_valid = 1'b1; wb_rd = 4'd3;
        @(negedge clk);
        wb_valid = 1'b0;
        #4; chk("t6_store_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        do_flush();

        // Randomized traffic; a word is held until accepted, as a fetch unit would.
        acc = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = rand_instr();
                in_pc    = in_pc + 32'd4;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = 4'($urandom_range(0, 3));
            flush     = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            #4;
            acc = in_valid && in_ready;
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0;
        repeat (4) @(negedge clk);
        #4; chk("drain_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
